rsa_keygen_ctrl: RTL and testbench
==================================

Name: rsa_keygen_ctrl

Overview:
Sequencer for RSA private-key generation. Given L = lcm(p-1, q-1), it runs the external public-exponent generator (E unit), then the external modular-inverse unit (D unit), and retries E when no inverse exists. It presents the final E/D pair to the top level with done/error status. Both units use the codebase's active-low start_n/ready_n handshake.

Parameters:
W, 64, datapath width of L, E, D
MAX_RETRY, 4, number of E candidates tried before giving up (1..15)
TIMEOUT, 4096, cycles allowed in each wait state before error (>=4)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
req  in  1  start key generation; sampled only in IDLE
abort  in  1  synchronous cancel; highest priority after rst
L_in  in  W  L value; latched on accepted req
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when E_out/D_out are valid
err  out  1  one-cycle pulse on failure
err_code  out  2  00 none, 01 E timeout, 10 D timeout, 11 retries exhausted/abort; held until next accepted req
E_out  out  W  accepted public exponent; held
D_out  out  W  private exponent; held
e_L  out  W  latched L, to E unit
e_start_n  out  1  active-low one-cycle start pulse to E unit
e_E  in  W  candidate E from E unit
e_ready_n  in  1  low = e_E valid (level)
d_E  out  W  latched candidate E, to D unit
d_L  out  W  latched L, to D unit
d_start_n  out  1  active-low one-cycle start pulse to D unit
d_D  in  W  inverse result
d_ok  in  1  valid with d_ready_n: 1 = gcd(E,L)=1 and d_D valid
d_ready_n  in  1  low = d_D/d_ok valid (level)

Behaviour:
- Reset (async): state IDLE, busy=0, done=0, err=0, err_code=00, e_start_n=1, d_start_n=1, E_out/D_out/e_L/d_E/d_L=0, retry and timeout counters=0.
- States: IDLE, E_START, E_WAIT, D_START, D_WAIT, FIN, FAIL.
- IDLE: on req=1, latch L_in into e_L/d_L, clear retry counter and err_code, go to E_START. req in any other state is ignored.
- E_START: e_start_n=0 for exactly this cycle. Clear the timeout counter. Go to E_WAIT.
- E_WAIT: e_ready_n is ignored in the first cycle, so stale ready from the previous result is masked. From the second cycle on, e_ready_n=0 latches e_E into d_E and goes to D_START.
- D_START / D_WAIT: same rules using d_start_n/d_ready_n.
  - On d_ready_n=0 with d_ok=1: latch d_E into E_OUT and d_D into D_out, go to FIN.
  - On d_ready_n=0 with d_ok=0: increment the retry counter. If the counter is now MAX_RETRY, set err_code=11 and go to FAIL; otherwise go to E_START (the E unit supplies the next candidate).
- Timeout: the counter increments every cycle in E_WAIT/D_WAIT. When it reaches TIMEOUT-1 without ready, set err_code 01 (E) or 10 (D) and go to FAIL. Ready arriving in that same cycle wins over the timeout.
- FIN: done=1 for one cycle, then IDLE. FAIL: err=1 for one cycle, then IDLE. E_out/D_out keep their last successful values on failure.
- abort=1 in any non-IDLE state: next state FAIL with err_code=11, no start pulse issued. abort in IDLE has no effect.
- Minimum latency, req to done with ready on the first eligible cycle: E_START(1) + E_WAIT(2) + D_START(1) + D_WAIT(2) + FIN = done asserted 7 cycles after the req edge.
- Start pulses never overlap; at most one unit is active at a time.

Test Plan:
- W=64, L_in=780; E unit returns 17 two cycles after its start; D unit returns d_ok=1, d_D=413 -> one e_start_n pulse, one d_start_n pulse; done pulse with E_out=17, D_out=413, err_code=00, busy low the next cycle.
- L_in=780; first candidate 15 (d_ok=0), second candidate 7 (d_ok=1, d_D=223) -> two e_start_n pulses; done with E_out=7, D_out=223.
- D unit always returns d_ok=0, MAX_RETRY=4 -> exactly 4 e_start_n pulses, then err pulse with err_code=11; E_out/D_out unchanged from the prior run.
- e_ready_n held low through E_START, TIMEOUT=16, D unit never ready -> stale ready is masked for one cycle, then accepted; err with err_code=10 exactly 16 cycles after the d_start_n pulse.
- abort asserted in D_WAIT, and separately rst asserted mid-E_WAIT -> abort: FAIL then IDLE, err_code=11. rst: all outputs immediately at reset values, no further start pulses.
- req pulsed while busy -> ignored; a new req one cycle after done starts a new run with freshly latched L.

Source files
------------

// File: rtl/rsa_keygen_ctrl.sv
// Sequencer for RSA private-key generation: drives the external public-exponent (E)
// and modular-inverse (D) units, retrying E whenever the candidate has no inverse mod L.
module rsa_keygen_ctrl #(
    parameter int W         = 64,
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         abort,
    input  logic [W-1:0] L_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [W-1:0] E_out,
    output logic [W-1:0] D_out,
    output logic [W-1:0] e_L,
    output logic         e_start_n,
    input  logic [W-1:0] e_E,
    input  logic         e_ready_n,
    output logic [W-1:0] d_E,
    output logic [W-1:0] d_L,
    output logic         d_start_n,
    input  logic [W-1:0] d_D,
    input  logic         d_ok,
    input  logic         d_ready_n
);

    typedef enum logic [2:0] {
        IDLE, E_START, E_WAIT, D_START, D_WAIT, FIN, FAIL
    } state_t;

    localparam int            TW          = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 2);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

    state_t        state, state_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic [3:0]    retry, retry_nx;
    logic [1:0]    code, code_nx;
    logic [W-1:0]  l_q, de_q, e_out_q, d_out_q;
    logic          ld_l, ld_e, ld_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // tmo==0 marks the first wait cycle, which doubles as the stale-ready mask
    always_comb begin
        state_nx = state;
        tmo_nx   = tmo;
        retry_nx = retry;
        code_nx  = code;
        ld_l     = 1'b0;
        ld_e     = 1'b0;
        ld_out   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = E_START;
                    ld_l     = 1'b1;
                    retry_nx = '0;
                    code_nx  = 2'b00;
                end
            end
            E_START: begin
                tmo_nx   = '0;
                state_nx = E_WAIT;
            end
            E_WAIT: begin
                tmo_nx = tmo + TW'(1);
                if (tmo != '0 && !e_ready_n) begin
                    ld_e     = 1'b1;
                    state_nx = D_START;
                end else if (tmo == TMO_LAST) begin
                    code_nx  = 2'b01;
                    state_nx = FAIL;
                end
            end
            D_START: begin
                tmo_nx   = '0;
                state_nx = D_WAIT;
            end
            D_WAIT: begin
                tmo_nx = tmo + TW'(1);
                if (tmo != '0 && !d_ready_n) begin
                    if (d_ok) begin
                        ld_out   = 1'b1;
                        state_nx = FIN;
                    end else begin
                        retry_nx = retry + 4'd1;
                        if (retry_nx == RETRY_LIMIT) begin
                            code_nx  = 2'b11;
                            state_nx = FAIL;
                        end else begin
                            state_nx = E_START;
                        end
                    end
                end else if (tmo == TMO_LAST) begin
                    code_nx  = 2'b10;
                    state_nx = FAIL;
                end
            end
            FIN:     state_nx = IDLE;
            FAIL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nx = FAIL;
            code_nx  = 2'b11;
            ld_e     = 1'b0;
            ld_out   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo     <= '0;
            retry   <= '0;
            code    <= 2'b00;
            l_q     <= '0;
            de_q    <= '0;
            e_out_q <= '0;
            d_out_q <= '0;
        end else begin
            tmo   <= tmo_nx;
            retry <= retry_nx;
            code  <= code_nx;
            if (ld_l) l_q <= L_in;
            if (ld_e) de_q <= e_E;
            if (ld_out) begin
                e_out_q <= de_q;
                d_out_q <= d_D;
            end
        end
    end

    // An abort during a start state suppresses that start pulse
    assign e_start_n = !(state == E_START && !abort);
    assign d_start_n = !(state == D_START && !abort);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign err       = (state == FAIL);
    assign err_code  = code;
    assign E_out     = e_out_q;
    assign D_out     = d_out_q;
    assign e_L       = l_q;
    assign d_L       = l_q;
    assign d_E       = de_q;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Scoreboard bench for rsa_keygen_ctrl: behavioural E/D unit responders, an attempt-level
// reference model producing expected results, and a monitor that checks every done/err pulse.
module tb_rsa_keygen_ctrl;

    localparam int W         = 64;
    localparam int MAX_RETRY = 4;
    localparam int TIMEOUT   = 16;
    localparam int NEVER     = 1000000;

    logic         clk = 1'b0;
    logic         rst, req, abort;
    logic [W-1:0] L_in;
    logic         busy, done, err;
    logic [1:0]   err_code;
    logic [W-1:0] E_out, D_out, e_L, d_E, d_L;
    logic         e_start_n, d_start_n;
    logic [W-1:0] e_E, d_D;
    logic         e_ready_n, d_ok, d_ready_n;

    always #5 clk = ~clk;

    rsa_keygen_ctrl #(.W(W), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .abort(abort), .L_in(L_in),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .E_out(E_out), .D_out(D_out), .e_L(e_L), .e_start_n(e_start_n),
        .e_E(e_E), .e_ready_n(e_ready_n), .d_E(d_E), .d_L(d_L),
        .d_start_n(d_start_n), .d_D(d_D), .d_ok(d_ok), .d_ready_n(d_ready_n)
    );

    typedef struct {
        bit          is_done;
        logic [1:0]  code;
        logic [63:0] e_out;
        logic [63:0] d_out;
        logic [63:0] last_de;
        logic [63:0] l;
        int          n_e;
        int          n_d;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [63:0] e_cands[MAX_RETRY];
    int          e_delay, d_delay;
    bit          d_force_fail, e_stale;
    int          e_idx;
    logic [63:0] prev_e = 0, prev_d = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          n_e_seen, n_d_seen;
    bit          overlap_seen;
    logic [63:0] de_seen, dl_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Extended Euclid: returns 1 and the inverse when gcd(e,l)=1
    function automatic bit mod_inv(input logic [63:0] e, input logic [63:0] l, output logic [63:0] inv);
        longint t, nt, r, nr, q, tmp;
        inv = 0;
        if (l == 0) return 1'b0;
        t = 0; nt = 1; r = longint'(l); nr = longint'(e % l);
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + longint'(l);
        inv = 64'(t);
        return (r == 1);
    endfunction

    // Reference model: walks candidate attempts in cycle units; cycle 0 is the req cycle
    function automatic exp_t model(input logic [63:0] l, input int abort_at);
        exp_t        x;
        int          c = 1, retries = 0, rc = 0, d, dd, limit;
        int          starts_e[$], starts_d[$];
        logic [63:0] de_list[$];
        logic [63:0] cand, inv;
        bit          fin = 0, ok;
        x.is_done = 0; x.code = 2'b00; x.e_out = prev_e; x.d_out = prev_d;
        x.l = l; x.last_de = 0; x.n_e = 0; x.n_d = 0;
        while (!fin) begin
            starts_e.push_back(c);
            d = (e_delay < 2) ? 2 : e_delay;
            if (d > TIMEOUT - 1) begin
                x.code = 2'b01; rc = c + TIMEOUT; fin = 1;
            end else begin
                cand = e_cands[starts_e.size() - 1];
                c = c + d + 1;
                starts_d.push_back(c);
                de_list.push_back(cand);
                dd = (d_delay < 2) ? 2 : d_delay;
                if (dd > TIMEOUT - 1) begin
                    x.code = 2'b10; rc = c + TIMEOUT; fin = 1;
                end else begin
                    ok = mod_inv(cand, l, inv);
                    if (d_force_fail) ok = 0;
                    rc = c + dd + 1;
                    if (ok) begin
                        x.is_done = 1; x.e_out = cand; x.d_out = inv; fin = 1;
                    end else begin
                        retries++;
                        if (retries == MAX_RETRY) begin
                            x.code = 2'b11; fin = 1;
                        end else begin
                            c = rc;
                        end
                    end
                end
            end
        end
        limit = NEVER;
        if (abort_at > 0 && abort_at < rc) begin
            x.is_done = 0; x.code = 2'b11; x.e_out = prev_e; x.d_out = prev_d;
            rc = abort_at + 1; limit = abort_at;
        end
        foreach (starts_e[i]) if (starts_e[i] < limit) x.n_e++;
        foreach (starts_d[i]) if (starts_d[i] < limit) begin
            x.n_d++; x.last_de = de_list[i];
        end
        x.lat = rc;
        return x;
    endfunction

    // E unit: candidate appears e_delay cycles after its start pulse and is held
    initial begin
        int  e_cnt = 0;
        bit  e_act = 0;
        e_ready_n = 1'b1; e_E = '0;
        forever begin
            @(negedge clk);
            if (!e_start_n) begin
                e_act = 1; e_cnt = 0;
                if (!e_stale) e_ready_n = 1'b1;
            end else if (e_act) begin
                e_cnt++;
            end
            if (e_act && e_cnt == e_delay) begin
                e_E = (e_idx < MAX_RETRY) ? e_cands[e_idx] : 64'd0;
                e_idx++;
                e_ready_n = 1'b0;
                e_act = 0;
            end
        end
    end

    // D unit: computes the real inverse of what the DUT handed it
    initial begin
        int          d_cnt = 0;
        bit          d_act = 0, ok;
        logic [63:0] inv;
        d_ready_n = 1'b1; d_D = '0; d_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!d_start_n) begin
                d_act = 1; d_cnt = 0; d_ready_n = 1'b1;
            end else if (d_act) begin
                d_cnt++;
            end
            if (d_act && d_cnt == d_delay) begin
                ok = mod_inv(d_E, d_L, inv);
                d_D = inv;
                d_ok = ok && !d_force_fail;
                d_ready_n = 1'b0;
                d_act = 0;
            end
        end
    end

    // Monitor: counts start pulses and checks each done/err pulse against the scoreboard
    initial begin
        exp_t x;
        n_e_seen = 0; n_d_seen = 0; overlap_seen = 0; de_seen = 0; dl_seen = 0;
        forever begin
            @(negedge clk);
            if (!e_start_n && !d_start_n) overlap_seen = 1;
            if (!e_start_n) n_e_seen++;
            if (!d_start_n) begin
                n_d_seen++; de_seen = d_E; dl_seen = d_L;
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_result: done=%0d err=%0d with empty scoreboard", done, err);
                end else begin
                    x = sb.pop_front();
                    checkOutput("done", done, x.is_done);
                    checkOutput("err", err, !x.is_done);
                    checkOutput("err_code", err_code, x.code);
                    checkOutput("E_out", E_out, x.e_out);
                    checkOutput("D_out", D_out, x.d_out);
                    checkOutput("e_start_pulses", n_e_seen, x.n_e);
                    checkOutput("d_start_pulses", n_d_seen, x.n_d);
                    checkOutput("latency", cyc - req_cyc, x.lat);
                    checkOutput("start_overlap", overlap_seen, 0);
                    if (x.n_d > 0) begin
                        checkOutput("d_E_at_start", de_seen, x.last_de);
                        checkOutput("d_L_at_start", dl_seen, x.l);
                    end
                    @(negedge clk);
                    checkOutput("busy_after", busy, 0);
                end
            end
        end
    end

    // Issues one req at a negedge while the DUT is idle; optional abort at cycle abort_at
    task automatic applyStimulus(input logic [63:0] l, input int abort_at);
        exp_t x;
        x = model(l, abort_at);
        if (x.is_done) begin
            prev_e = x.e_out; prev_d = x.d_out;
        end
        sb.push_back(x);
        e_idx = 0; n_e_seen = 0; n_d_seen = 0; overlap_seen = 0;
        L_in = l; req = 1'b1; req_cyc = cyc;
        @(negedge clk);
        req = 1'b0; L_in = {$urandom, $urandom};
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    task automatic waitResult();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("[TB] FAIL result_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_err_code"}, err_code, 0);
        checkOutput({tag, "_e_start_n"}, e_start_n, 1);
        checkOutput({tag, "_d_start_n"}, d_start_n, 1);
        checkOutput({tag, "_E_out"}, E_out, 0);
        checkOutput({tag, "_D_out"}, D_out, 0);
        checkOutput({tag, "_e_L"}, e_L, 0);
        checkOutput({tag, "_d_E"}, d_E, 0);
        checkOutput({tag, "_d_L"}, d_L, 0);
    endtask

    task automatic setCands(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
        e_cands[0] = a; e_cands[1] = b; e_cands[2] = c; e_cands[3] = d;
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 1'b0; abort = 1'b0; L_in = '0;
        e_delay = 2; d_delay = 2; d_force_fail = 0; e_stale = 0; e_idx = 0;
        setCands(3, 5, 7, 11);
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single candidate, minimum latency");
        setCands(17, 19, 23, 29);
        applyStimulus(780, 0);
        waitResult();
        checkOutput("t1_E_out", E_out, 17);
        checkOutput("t1_D_out", D_out, 413);
        checkOutput("t1_err_code", err_code, 0);

        $display("[TB] first candidate rejected, second accepted");
        setCands(15, 7, 11, 13);
        applyStimulus(780, 0);
        waitResult();
        checkOutput("t2_E_out", E_out, 7);
        checkOutput("t2_D_out", D_out, 223);

        $display("[TB] retries exhausted");
        d_force_fail = 1;
        setCands(101, 103, 107, 109);
        applyStimulus(780, 0);
        waitResult();
        checkOutput("t3_err_code", err_code, 2'b11);
        checkOutput("t3_E_held", E_out, 7);
        checkOutput("t3_D_held", D_out, 223);
        d_force_fail = 0;

        $display("[TB] stale E ready masked, D timeout");
        e_stale = 1; e_delay = 2; d_delay = NEVER;
        setCands(29, 31, 37, 41);
        applyStimulus(780, 0);
        waitResult();
        e_stale = 0;

        $display("[TB] abort in D_WAIT");
        e_delay = 2; d_delay = NEVER;
        setCands(43, 47, 53, 59);
        applyStimulus(780, 7);
        waitResult();
        checkOutput("t5_err_code", err_code, 2'b11);

        $display("[TB] req ignored while busy, back-to-back req after done");
        e_delay = 3; d_delay = 3;
        setCands(3, 7, 9, 11);
        applyStimulus(1000, 0);
        repeat (2) @(negedge clk);
        L_in = 999; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        checkOutput("t6_done_seen", done, 1);
        @(negedge clk);
        e_delay = 1; d_delay = 4;
        setCands(5, 7, 11, 13);
        applyStimulus(2021, 0);
        waitResult();

        $display("[TB] randomized runs");
        for (int r = 0; r < 24; r++) begin
            e_delay = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 6));
            d_delay = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 6));
            d_force_fail = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < MAX_RETRY; k++) e_cands[k] = 64'($urandom_range(3, 70000));
            applyStimulus(64'($urandom_range(100, 200000)), 0);
            waitResult();
        end
        d_force_fail = 0;

        $display("[TB] async reset in E_WAIT");
        e_delay = NEVER; d_delay = 2;
        L_in = 555; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetValues("midrun_reset");
        prev_e = 0; prev_d = 0;
        @(negedge clk);
        rst = 1'b0;
        n_e_seen = 0; n_d_seen = 0;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_e_starts", n_e_seen, 0);
        checkOutput("post_reset_busy", busy, 0);

        e_delay = 2; d_delay = 2;
        setCands(17, 19, 23, 29);
        applyStimulus(780, 0);
        waitResult();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
